// File: rtl/qsys_regbank_pkg.sv
// Shared constants, FSM state type and parameter helpers for the qsys_regbank slave.
package qsys_regbank_pkg;

   localparam int unsigned ADDR_ID      = 0;
   localparam int unsigned ADDR_RW_BASE = 1;

   typedef enum logic {
      HOLD  = 1'b0,
      READY = 1'b1
   } state_e;

   function automatic int unsigned addr_cnt(input int unsigned num_rw);
      return num_rw + 1;
   endfunction

   // The ID word, every RW register and the counter must fit in the address space.
   function automatic bit aw_ok(input int unsigned aw, input int unsigned num_rw);
      return (64'd1 << aw) >= 64'(num_rw + 2);
   endfunction

endpackage

// File: rtl/qsys_regbank_reg.sv
// One byte-enabled register with a registered write strobe.
module qsys_regbank_reg #(
   parameter int unsigned          DATA_W    = 32,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    we_i,
   input  logic [DATA_W/8-1:0]     be_i,
   input  logic [DATA_W-1:0]       wdata_i,
   output logic [DATA_W-1:0]       q_o,
   output logic                    strobe_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              strobe_q;

   always_comb begin
      data_d = data_q;
      if (we_i) begin
         for (int unsigned b = 0; b < DATA_W/8; b++) begin
            if (be_i[b]) data_d[b*8 +: 8] = wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q   <= RESET_VAL;
         strobe_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         strobe_q <= we_i;
      end
   end

   assign q_o      = data_q;
   assign strobe_o = strobe_q;

endmodule

// File: rtl/qsys_regbank.sv
// Avalon-MM register bank: ID word, NUM_RW byte-writable registers and a saturating
// write counter, with 1-cycle pipelined reads and a post-reset waitrequest hold-off.
module qsys_regbank
   import qsys_regbank_pkg::*;
#(
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          NUM_RW    = 4,
   parameter int unsigned          AW        = 4,
   parameter logic [31:0]          ID_VALUE  = 32'h12345678,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0,
   parameter int unsigned          HOLD_CYC  = 2
) (
   input  logic                       csi_MCLK_clk,
   input  logic                       rsi_MRST_reset_n,
   input  logic [AW-1:0]              avs_Regs_address,
   input  logic                       avs_Regs_read,
   output logic [DATA_W-1:0]          avs_Regs_readdata,
   output logic                       avs_Regs_readdatavalid,
   input  logic                       avs_Regs_write,
   input  logic [DATA_W-1:0]          avs_Regs_writedata,
   input  logic [DATA_W/8-1:0]        avs_Regs_byteenable,
   output logic                       avs_Regs_waitrequest,
   output logic [NUM_RW*DATA_W-1:0]   coe_Regs_export,
   output logic [NUM_RW-1:0]          coe_Regs_wrstrobe
);

   localparam int unsigned       ADDR_CNT = addr_cnt(NUM_RW);
   localparam logic [DATA_W-1:0] ID_WORD  = DATA_W'(ID_VALUE);

   if (!aw_ok(AW, NUM_RW)) begin : g_bad_aw
      $error("qsys_regbank: AW too small for NUM_RW+2 words");
   end

   state_e                       state_q, state_d;
   logic [3:0]                   hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0]            cnt_q, cnt_d;
   logic [DATA_W-1:0]            rdata_q, rdata_d;
   logic                         rvalid_q;
   logic [DATA_W-1:0]            rd_mux;
   logic [NUM_RW-1:0]            wr_sel;
   logic [NUM_RW-1:0][DATA_W-1:0] rw_val;
   logic [31:0]                  addr_u;
   logic                         rd_acc, wr_acc;

   assign avs_Regs_waitrequest = (state_q != READY);
   assign rd_acc = avs_Regs_read  && !avs_Regs_waitrequest;
   assign wr_acc = avs_Regs_write && !avs_Regs_waitrequest;
   assign addr_u = 32'(avs_Regs_address);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         HOLD: begin
            if (32'(hold_cnt_q) == HOLD_CYC - 1) state_d = READY;
            else                                 hold_cnt_d = hold_cnt_q + 4'd1;
         end
         READY: ;
      endcase
   end

   // Read mux sees register values before this cycle's write lands.
   always_comb begin
      wr_sel  = '0;
      rd_mux  = '0;
      cnt_d   = cnt_q;
      if (addr_u == ADDR_ID)  rd_mux = ID_WORD;
      if (addr_u == ADDR_CNT) rd_mux = cnt_q;
      for (int unsigned k = 0; k < NUM_RW; k++) begin
         if (addr_u == k + ADDR_RW_BASE) begin
            rd_mux    = rw_val[k];
            wr_sel[k] = wr_acc;
         end
      end
      if (wr_acc && addr_u == ADDR_CNT)  cnt_d = '0;
      else if (|wr_sel && cnt_q != '1)   cnt_d = cnt_q + DATA_W'(1);
      rdata_d = rd_acc ? rd_mux : rdata_q;
   end

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         state_q    <= HOLD;
         hold_cnt_q <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rd_acc;
      end
   end

   for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
      qsys_regbank_reg #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_reg (
         .clk_i    (csi_MCLK_clk),
         .rst_ni   (rsi_MRST_reset_n),
         .we_i     (wr_sel[k]),
         .be_i     (avs_Regs_byteenable),
         .wdata_i  (avs_Regs_writedata),
         .q_o      (rw_val[k]),
         .strobe_o (coe_Regs_wrstrobe[k])
      );
   end

   assign coe_Regs_export        = rw_val;
   assign avs_Regs_readdata      = rdata_q;
   assign avs_Regs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_qsys_regbank.sv
// Randomised self-checking bench for qsys_regbank against an array-based register map model.
module tb_qsys_regbank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  address = '0;
   logic        read = 1'b0, write = 1'b0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] readdata;
   logic        readdatavalid, waitrequest;
   logic [127:0] exp_o;
   logic [3:0]  wrstrobe;

   logic [1:0]  address8 = '0;
   logic        read8 = 1'b0, write8 = 1'b0;
   logic [7:0]  writedata8 = '0;
   logic        byteenable8 = 1'b0;
   logic [7:0]  readdata8;
   logic        readdatavalid8, waitrequest8;
   logic [15:0] exp8;
   logic [1:0]  wrstrobe8;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_rw [4];
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   qsys_regbank #(.DATA_W(32), .NUM_RW(4), .AW(4), .ID_VALUE(32'h12345678),
                  .RESET_VAL(32'h0), .HOLD_CYC(2)) dut (
      .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
      .avs_Regs_address(address), .avs_Regs_read(read),
      .avs_Regs_readdata(readdata), .avs_Regs_readdatavalid(readdatavalid),
      .avs_Regs_write(write), .avs_Regs_writedata(writedata),
      .avs_Regs_byteenable(byteenable), .avs_Regs_waitrequest(waitrequest),
      .coe_Regs_export(exp_o), .coe_Regs_wrstrobe(wrstrobe));

   qsys_regbank #(.DATA_W(8), .NUM_RW(2), .AW(2), .ID_VALUE(32'h12345678),
                  .RESET_VAL(8'h0), .HOLD_CYC(2)) dut8 (
      .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
      .avs_Regs_address(address8), .avs_Regs_read(read8),
      .avs_Regs_readdata(readdata8), .avs_Regs_readdatavalid(readdatavalid8),
      .avs_Regs_write(write8), .avs_Regs_writedata(writedata8),
      .avs_Regs_byteenable(byteenable8), .avs_Regs_waitrequest(waitrequest8),
      .coe_Regs_export(exp8), .coe_Regs_wrstrobe(wrstrobe8));

   function automatic logic [31:0] m_read(input int a);
      if (a == 0) return 32'h12345678;
      if (a >= 1 && a <= 4) return m_rw[a-1];
      if (a == 5) return m_cnt;
      return 32'h0;
   endfunction

   function automatic logic [127:0] m_export();
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[k*32 +: 32] = m_rw[k];
      return v;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 4; k++) m_rw[k] = 32'h0;
      m_cnt = 32'h0;
   endtask

   task automatic m_write(input int a, input logic [31:0] d, input logic [3:0] be);
      if (a >= 1 && a <= 4) begin
         for (int b = 0; b < 4; b++) if (be[b]) m_rw[a-1][b*8 +: 8] = d[b*8 +: 8];
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (a == 5) begin
         m_cnt = 32'h0;
      end
   endtask

   // One bus cycle; outputs are sampled 1 ns after the accepting edge.
   task automatic bus(input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
      read = rd; write = wr; address = a; writedata = d; byteenable = be;
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
   endtask

   task automatic release_and_check_hold(input string tag);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (waitrequest !== 1'b1) begin
         errors++; $display("FAIL %s_hold1 waitrequest=%b expected 1", tag, waitrequest);
      end
      @(posedge clk); #1;
      checks++;
      if (waitrequest !== 1'b0) begin
         errors++; $display("FAIL %s_hold2 waitrequest=%b expected 0", tag, waitrequest);
      end
   endtask

   task automatic test_reset();
      m_reset();
      #3;
      checks++;
      if (waitrequest !== 1'b1 || readdatavalid !== 1'b0 || readdata !== 32'h0 ||
          wrstrobe !== 4'h0 || exp_o !== 128'h0) begin
         errors++;
         $display("FAIL reset_state wr=%b rv=%b rd=%h st=%b exp=%h expected 1 0 0 0 0",
                  waitrequest, readdatavalid, readdata, wrstrobe, exp_o);
      end
      // Requests held through the hold-off window must be dropped.
      read = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
      release_and_check_hold("reset");
      read = 1'b0; write = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (readdatavalid !== 1'b0 || wrstrobe !== 4'h0 || exp_o !== 128'h0) begin
         errors++;
         $display("FAIL hold_drop rv=%b st=%b exp=%h expected 0 0 0", readdatavalid, wrstrobe, exp_o);
      end
   endtask

   task automatic test_id_read();
      bus(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h12345678) begin
         errors++; $display("FAIL id_read rv=%b rd=%h expected 1 12345678", readdatavalid, readdata);
      end
      @(posedge clk); #1;
      checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h12345678) begin
         errors++; $display("FAIL id_hold rv=%b rd=%h expected 0 12345678", readdatavalid, readdata);
      end
   endtask

   task automatic test_byte_write();
      bus(1'b0, 1'b1, 4'd2, 32'hAABBCCDD, 4'b0101);
      m_write(2, 32'hAABBCCDD, 4'b0101);
      checks++;
      if (exp_o[63:32] !== 32'h00BB00DD || wrstrobe !== 4'b0010) begin
         errors++; $display("FAIL byte_write reg1=%h st=%b expected 00bb00dd 0010", exp_o[63:32], wrstrobe);
      end
      @(posedge clk); #1;
      checks++;
      if (wrstrobe !== 4'b0000) begin
         errors++; $display("FAIL strobe_pulse st=%b expected 0000", wrstrobe);
      end
      bus(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
      checks++;
      if (readdata !== 32'd1 || readdatavalid !== 1'b1) begin
         errors++; $display("FAIL count_one rd=%h rv=%b expected 1 1", readdata, readdatavalid);
      end
      bus(1'b0, 1'b1, 4'd3, 32'h12345678, 4'b0000);
      m_write(3, 32'h12345678, 4'b0000);
      checks++;
      if (wrstrobe !== 4'b0100 || exp_o !== m_export()) begin
         errors++; $display("FAIL be_zero st=%b exp=%h expected 0100 %h", wrstrobe, exp_o, m_export());
      end
   endtask

   task automatic test_rw_same_cycle();
      bus(1'b1, 1'b1, 4'd1, 32'h1, 4'hF);
      m_write(1, 32'h1, 4'hF);
      checks++;
      if (readdata !== 32'h0 || readdatavalid !== 1'b1) begin
         errors++; $display("FAIL rw_same rd=%h rv=%b expected 0 1", readdata, readdatavalid);
      end
      bus(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
      checks++;
      if (readdata !== 32'h1) begin
         errors++; $display("FAIL rw_after rd=%h expected 1", readdata);
      end
   endtask

   task automatic test_ignored();
      logic [3:0] al [3];
      al[0] = 4'd0; al[1] = 4'd7; al[2] = 4'd15;
      for (int i = 0; i < 3; i++) begin
         bus(1'b0, 1'b1, al[i], 32'hDEADBEEF, 4'hF);
         checks++;
         if (wrstrobe !== 4'h0 || exp_o !== m_export()) begin
            errors++; $display("FAIL ign_write a=%0d st=%b exp=%h", al[i], wrstrobe, exp_o);
         end
      end
      for (int i = 0; i < 3; i++) begin
         bus(1'b1, 1'b0, al[i], 32'h0, 4'h0);
         checks++;
         if (readdata !== m_read(int'(al[i]))) begin
            errors++; $display("FAIL ign_read a=%0d rd=%h expected %h", al[i], readdata, m_read(int'(al[i])));
         end
      end
      bus(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
      checks++;
      if (readdata !== m_cnt) begin
         errors++; $display("FAIL ign_count rd=%h expected %h", readdata, m_cnt);
      end
      bus(1'b0, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'hF);
      m_write(5, 32'hFFFF_FFFF, 4'hF);
      bus(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
      checks++;
      if (readdata !== 32'h0) begin
         errors++; $display("FAIL count_clear rd=%h expected 0", readdata);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 4; k++) begin
         bus(1'b1, 1'b0, 4'(k), 32'h0, 4'h0);
         checks++;
         if (readdatavalid !== 1'b1 || readdata !== m_read(k)) begin
            errors++; $display("FAIL b2b a=%0d rv=%b rd=%h expected 1 %h", k, readdatavalid, readdata, m_read(k));
         end
      end
   endtask

   task automatic test_random();
      logic        rd, wr;
      logic [3:0]  a, be, st_exp;
      logic [31:0] d, rexp, last_rd;
      last_rd = readdata;
      for (int i = 0; i < 300; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
         d  = $urandom;
         be = 4'($urandom);
         rexp   = rd ? m_read(int'(a)) : last_rd;
         st_exp = (wr && a >= 1 && a <= 4) ? (4'b0001 << (a - 1)) : 4'b0000;
         if (wr) m_write(int'(a), d, be);
         bus(rd, wr, a, d, be);
         checks++;
         if (readdatavalid !== rd || readdata !== rexp || wrstrobe !== st_exp || exp_o !== m_export()) begin
            errors++;
            $display("FAIL random i=%0d rv=%b rd=%h st=%b exp=%h expected %b %h %b %h",
                     i, readdatavalid, readdata, wrstrobe, exp_o, rd, rexp, st_exp, m_export());
         end
         last_rd = rexp;
      end
   endtask

   task automatic test_saturation();
      write8 = 1'b1; address8 = 2'd1; byteenable8 = 1'b1;
      for (int i = 0; i < 260; i++) begin
         writedata8 = 8'(i);
         @(posedge clk); #1;
      end
      write8 = 1'b0;
      read8 = 1'b1; address8 = 2'd3;
      @(posedge clk); #1;
      checks++;
      if (readdata8 !== 8'hFF || readdatavalid8 !== 1'b1 || exp8[7:0] !== 8'd3) begin
         errors++; $display("FAIL saturate cnt=%h rv=%b reg0=%h expected ff 1 03", readdata8, readdatavalid8, exp8[7:0]);
      end
      address8 = 2'd0;
      @(posedge clk); #1;
      read8 = 1'b0;
      checks++;
      if (readdata8 !== 8'h78) begin
         errors++; $display("FAIL id_trunc rd=%h expected 78", readdata8);
      end
   endtask

   task automatic test_reset_mid();
      bus(1'b0, 1'b1, 4'd3, 32'hCAFEF00D, 4'hF);
      m_write(3, 32'hCAFEF00D, 4'hF);
      checks++;
      if (exp_o !== m_export()) begin
         errors++; $display("FAIL pre_reset exp=%h expected %h", exp_o, m_export());
      end
      read = 1'b1; write = 1'b1; address = 4'd2; writedata = 32'h55AA55AA; byteenable = 4'hF;
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if (exp_o !== 128'h0 || waitrequest !== 1'b1 || readdatavalid !== 1'b0 || readdata !== 32'h0) begin
         errors++;
         $display("FAIL async_reset exp=%h wr=%b rv=%b rd=%h expected 0 1 0 0", exp_o, waitrequest, readdatavalid, readdata);
      end
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
      checks++;
      if (readdatavalid !== 1'b0 || wrstrobe !== 4'h0 || exp_o !== 128'h0) begin
         errors++; $display("FAIL reset_pending rv=%b st=%b exp=%h expected 0 0 0", readdatavalid, wrstrobe, exp_o);
      end
      release_and_check_hold("rerst");
      bus(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin
         errors++; $display("FAIL post_reset rv=%b rd=%h expected 1 0", readdatavalid, readdata);
      end
   endtask

   initial begin
      test_reset();
      test_id_read();
      test_byte_write();
      test_rw_same_cycle();
      test_ignored();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/qsys_regbank.md
Name: qsys_regbank

Overview:
- Parametrised Avalon-MM slave register bank for Qsys systems.
- Contains one read-only ID word, NUM_RW byte-writable control/scratch registers and a read-only write counter.
- Adds byte enables, pipelined reads with readdatavalid, and a post-reset hold-off on waitrequest.
- Exports all RW registers and per-register write strobes to fabric logic.

Parameters:
- DATA_W, 32, register width in bits; multiple of 8.
- NUM_RW, 4, number of RW registers; range 1..14.
- AW, 4, address width; must satisfy 2**AW >= NUM_RW+2.
- ID_VALUE, 32'h12345678, constant returned at address 0 (truncated/zero-extended to DATA_W).
- RESET_VAL, 32'h0, reset value of every RW register.
- HOLD_CYC, 2, cycles waitrequest stays high after reset release; range 1..15.

Ports:
- csi_MCLK_clk  in  1  system clock; all logic on rising edge.
- rsi_MRST_reset_n  in  1  reset, asynchronous assert, active-low.
- avs_Regs_address  in  AW  word address.
- avs_Regs_read  in  1  read request.
- avs_Regs_readdata  out  DATA_W  read data, valid with readdatavalid.
- avs_Regs_readdatavalid  out  1  one-cycle read-data qualifier.
- avs_Regs_write  in  1  write request.
- avs_Regs_writedata  in  DATA_W  write data.
- avs_Regs_byteenable  in  DATA_W/8  byte lane enables for writes.
- avs_Regs_waitrequest  out  1  stall; requests ignored while high.
- coe_Regs_export  out  NUM_RW*DATA_W  RW register contents; register k at bits [k*DATA_W +: DATA_W].
- coe_Regs_wrstrobe  out  NUM_RW  one-cycle pulse, bit k, on an accepted write to RW register k.

Behaviour:
- Interface: one clock, csi_MCLK_clk. Reset rsi_MRST_reset_n is asynchronous and active-low.
- Reset (rsi_MRST_reset_n=0), all outputs async:
  - RW regs = RESET_VAL; counter = 0.
  - readdata = 0; readdatavalid = 0; wrstrobe = 0.
  - waitrequest = 1; FSM = HOLD with hold counter = 0.
- FSM:
  - HOLD: waitrequest=1; counter increments each cycle; go to READY when it reaches HOLD_CYC-1.
  - READY: waitrequest=0. Reset assertion in any state returns to HOLD immediately.
- Acceptance: a request is accepted in a cycle where waitrequest=0 and read or write=1. Requests during HOLD are dropped, not queued.
- Address map:
  - 0 = ID, read-only; writes ignored.
  - 1..NUM_RW = RW register k = address-1.
  - NUM_RW+1 = write counter, read-only value; any accepted write clears it to 0.
  - Higher addresses: read returns 0, write ignored, no strobe.
- Write:
  - Byte lane b is updated when byteenable[b]=1 at the clock edge of acceptance; new value visible on export the next cycle.
  - wrstrobe[k] is high the cycle after acceptance, even if byteenable=0.
- Write counter:
  - DATA_W bits; +1 per accepted write to any RW register.
  - Saturates at all-ones; no wrap.
- Read:
  - Latency 1: readdata registered and readdatavalid=1 exactly one cycle after acceptance.
  - readdata holds its last value when readdatavalid=0.
  - Back-to-back reads give back-to-back valids.
- Simultaneous read+write in one cycle: both accepted. Read returns the pre-write value; write applies normally.
- Reset mid-read: the pending readdatavalid is suppressed.

Decomposition:
- Package qsys_regbank_pkg:
  - address constants ADDR_ID=0, ADDR_RW_BASE=1.
  - function addr_cnt(NUM_RW)=NUM_RW+1.
  - FSM state enum {HOLD, READY}.
  - function for AW minimum check.
- Sub-module qsys_regbank_reg: one byte-enabled DATA_W register with async active-low reset to RESET_VAL, write enable and strobe output; instantiated NUM_RW times via generate.
- Counter, FSM and read mux stay in the top.

Test Plan:
- Reset release, NUM_RW=4, HOLD_CYC=2 → waitrequest=1 for exactly 2 cycles after reset_n rises, then 0. Read addr 0 → readdata=32'h12345678 with readdatavalid 1 cycle later.
- Write addr 2 data 32'hAABBCCDD, byteenable=4'b0101 → export reg1 = 32'h00BB00DD. wrstrobe=4'b0010 for one cycle. Read addr 5 returns 1.
- Same-cycle read+write addr 1 (write 32'h1, prior value 0) → readdata=0; a following read returns 32'h1.
- Write addr 0, addr 7 and addr 15 → ID unchanged, reads of 7/15 return 0, no strobes, counter unchanged. Then write addr 5 → counter reads 0.
- Counter forced near saturation (DATA_W=8 build, 260 writes to addr 1) → counter reads 8'hFF.
- Assert reset_n=0 during a pending read and during a write → readdatavalid stays 0; all regs return to RESET_VAL asynchronously; HOLD re-entered.
